// File: rtl/peripheral_dbg_pu_riscv_pkg.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_pu_riscv_pkg
//
// Shared types for the RISC-V debug CPU-access path:
//   seq_state_e : sequencer FSM states (IDLE / ACCESS / RESP)
//   dbg_cmd_t   : latched CPU access command (core, addr, data, we)
//   dbg_rsp_t   : response returned to the debug module (data, err)
//
// The struct fields are sized to the widest supported configuration.
// Users zero-extend into them and slice back to their own widths.
// ---------------------------------------------------------------------------
package peripheral_dbg_pu_riscv_pkg;

  localparam int DBG_IDX_MAX_W  = 16;
  localparam int DBG_ADDR_MAX_W = 64;
  localparam int DBG_DATA_MAX_W = 64;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'd0,
    SEQ_ACCESS = 2'd1,
    SEQ_RESP   = 2'd2
  } seq_state_e;

  typedef struct packed {
    logic [DBG_IDX_MAX_W-1:0]  core;
    logic [DBG_ADDR_MAX_W-1:0] addr;
    logic [DBG_DATA_MAX_W-1:0] data;
    logic                      we;
  } dbg_cmd_t;

  typedef struct packed {
    logic [DBG_DATA_MAX_W-1:0] data;
    logic                      err;
  } dbg_rsp_t;

  // Core index width: $clog2(cores), but never narrower than one bit.
  function automatic int dbg_idx_width(input int cores);
    return (cores > 1) ? $clog2(cores) : 1;
  endfunction

endpackage

// File: rtl/peripheral_dbg_pu_riscv_stall_ctrl.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_pu_riscv_stall_ctrl
//
// Per-core stall register vector. Each bit is set by a breakpoint or by a
// host stall request, and cleared by a host unstall request. Set beats clear
// on the same cycle, so a breakpoint held high keeps its core stalled.
//
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset (clears all stalls)
//   bp_i     : [N] per-core breakpoint
//   set_i    : [N] host stall request
//   clr_i    : [N] host unstall request
//   stall_o  : [N] registered per-core stall
// ---------------------------------------------------------------------------
module peripheral_dbg_pu_riscv_stall_ctrl
  import peripheral_dbg_pu_riscv_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] bp_i,
  input  logic [N-1:0] set_i,
  input  logic [N-1:0] clr_i,
  output logic [N-1:0] stall_o
);

  logic [N-1:0] stall_q;
  logic [N-1:0] stall_d;

  for (genvar gi = 0; gi < N; gi++) begin : g_stall
    assign stall_d[gi] = (bp_i[gi] | set_i[gi]) ? 1'b1 :
                         clr_i[gi]              ? 1'b0 : stall_q[gi];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_o = stall_q;

endmodule

// File: rtl/peripheral_dbg_pu_riscv_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// peripheral_dbg_pu_riscv_cpu_sequencer
//
// Sequences single debug CPU register/memory accesses onto the per-core CPU
// debug ports. One command is outstanding at a time: it is accepted in IDLE,
// strobed onto the selected core only in ACCESS until that core acks, and
// returned as a response in RESP until consumed. Also owns the per-core
// stall vector.
//
// Optional feature macro: PERIPHERAL_DBG_CPU_TIMEOUT_EN
//   defined   : ACCESS gives up after TIMEOUT cycles without ack (err=1)
//   undefined : ACCESS waits for ack indefinitely, no counter
//
// Ports:
//   cpu_clk_i / cpu_rst_i      : clock, synchronous active-high reset
//   req_valid_i / req_ready_o  : command handshake
//   req_core_i/addr/data/we    : command (core index, address, data, write)
//   rsp_valid_o / rsp_ready_i  : response handshake
//   rsp_data_o / rsp_err_o     : read data (0 on write/error), error flag
//   cpu_addr_o/data_o/stb_o/we_o : per-core debug port outputs (flattened)
//   cpu_data_i / cpu_ack_i     : per-core read data and ack
//   cpu_bp_i, stall_set_i, stall_clr_i, cpu_stall_o : stall control
// ---------------------------------------------------------------------------
module peripheral_dbg_pu_riscv_cpu_sequencer
  import peripheral_dbg_pu_riscv_pkg::*;
#(
  parameter int  CORES          = 32,
  parameter int  CPU_ADDR_WIDTH = 32,
  parameter int  CPU_DATA_WIDTH = 32,
  parameter int  TIMEOUT        = 255,
  localparam int IDXW           = dbg_idx_width(CORES)
) (
  input  logic                               cpu_clk_i,
  input  logic                               cpu_rst_i,

  input  logic                               req_valid_i,
  output logic                               req_ready_o,
  input  logic [IDXW-1:0]                    req_core_i,
  input  logic [CPU_ADDR_WIDTH-1:0]          req_addr_i,
  input  logic [CPU_DATA_WIDTH-1:0]          req_data_i,
  input  logic                               req_we_i,

  output logic                               rsp_valid_o,
  input  logic                               rsp_ready_i,
  output logic [CPU_DATA_WIDTH-1:0]          rsp_data_o,
  output logic                               rsp_err_o,

  output logic [CORES*CPU_ADDR_WIDTH-1:0]    cpu_addr_o,
  output logic [CORES*CPU_DATA_WIDTH-1:0]    cpu_data_o,
  input  logic [CORES*CPU_DATA_WIDTH-1:0]    cpu_data_i,
  output logic [CORES-1:0]                   cpu_stb_o,
  output logic [CORES-1:0]                   cpu_we_o,
  input  logic [CORES-1:0]                   cpu_ack_i,

  input  logic [CORES-1:0]                   cpu_bp_i,
  input  logic [CORES-1:0]                   stall_set_i,
  input  logic [CORES-1:0]                   stall_clr_i,
  output logic [CORES-1:0]                   cpu_stall_o
);

  localparam int AW = CPU_ADDR_WIDTH;
  localparam int DW = CPU_DATA_WIDTH;

  // One extra bit so the out-of-range test also works for power-of-two CORES.
  localparam logic [IDXW:0] CORES_LIM = (IDXW+1)'(CORES);

  seq_state_e state_q, state_d;
  dbg_cmd_t   cmd_q,   cmd_d;
  dbg_rsp_t   rsp_q,   rsp_d;

  logic [CORES-1:0] lane_sel;
  logic [DW-1:0]    rd_lane [CORES];
  logic [DW-1:0]    rd_data;
  logic             sel_ack;

`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
  localparam int             TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  // Last no-ack cycle: the count reaches TIMEOUT on this cycle.
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  logic [TMO_W-1:0] tmo_q, tmo_d;
`else
  localparam int unused_timeout = TIMEOUT;
`endif

  // -------------------------------------------------------------------------
  // Lane demux: only the latched core sees strobe/we/addr/data, and only its
  // read data / ack feed back. Everything is gated by ACCESS so the lanes
  // fall to zero the cycle after ack, timeout or reset.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < CORES; gi++) begin : g_lane
    assign lane_sel[gi] = (state_q == SEQ_ACCESS) &&
                          (cmd_q.core[IDXW-1:0] == IDXW'(gi));
    assign cpu_stb_o[gi] = lane_sel[gi];
    assign cpu_we_o[gi]  = lane_sel[gi] & cmd_q.we;
    assign cpu_addr_o[gi*AW +: AW] = lane_sel[gi] ? cmd_q.addr[AW-1:0] : '0;
    assign cpu_data_o[gi*DW +: DW] = lane_sel[gi] ? cmd_q.data[DW-1:0] : '0;
    assign rd_lane[gi] = lane_sel[gi] ? cpu_data_i[gi*DW +: DW] : '0;
  end

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < CORES; i++) begin
      rd_data = rd_data | rd_lane[i];
    end
  end

  // Acks on non-selected lanes are masked out here.
  assign sel_ack = |(cpu_ack_i & lane_sel);

  // -------------------------------------------------------------------------
  // Sequencer FSM
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    rsp_d   = rsp_q;
`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    case (state_q)
      SEQ_IDLE: begin
        if (req_valid_i) begin
          cmd_d.core = DBG_IDX_MAX_W'(req_core_i);
          cmd_d.addr = DBG_ADDR_MAX_W'(req_addr_i);
          cmd_d.data = DBG_DATA_MAX_W'(req_data_i);
          cmd_d.we   = req_we_i;
          if ({1'b0, req_core_i} >= CORES_LIM) begin
            // Nonexistent core: answer with an error, never strobe.
            rsp_d.data = '0;
            rsp_d.err  = 1'b1;
            state_d    = SEQ_RESP;
          end else begin
            state_d = SEQ_ACCESS;
`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
            tmo_d   = '0;
`endif
          end
        end
      end
      SEQ_ACCESS: begin
        // Ack is checked first so an ack on the final timeout cycle wins.
        if (sel_ack) begin
          rsp_d.data = cmd_q.we ? '0 : DBG_DATA_MAX_W'(rd_data);
          rsp_d.err  = 1'b0;
          state_d    = SEQ_RESP;
        end
`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          rsp_d.data = '0;
          rsp_d.err  = 1'b1;
          state_d    = SEQ_RESP;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      SEQ_RESP: begin
        if (rsp_ready_i) begin
          state_d = SEQ_IDLE;
        end
      end
      default: begin
        state_d = SEQ_IDLE;
      end
    endcase
  end

  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q <= SEQ_IDLE;
      cmd_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rsp_q   <= rsp_d;
    end
  end

`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  // Upper bits of the max-width command/response structs are never read.
  logic unused_struct_bits;
  assign unused_struct_bits = ^{cmd_q, rsp_q};

  assign req_ready_o = (state_q == SEQ_IDLE);
  assign rsp_valid_o = (state_q == SEQ_RESP);
  assign rsp_data_o  = rsp_q.data[DW-1:0];
  assign rsp_err_o   = rsp_q.err;

  // -------------------------------------------------------------------------
  // Per-core stall vector
  // -------------------------------------------------------------------------
  peripheral_dbg_pu_riscv_stall_ctrl #(
    .N (CORES)
  ) u_stall_ctrl (
    .clk_i   (cpu_clk_i),
    .rst_i   (cpu_rst_i),
    .bp_i    (cpu_bp_i),
    .set_i   (stall_set_i),
    .clr_i   (stall_clr_i),
    .stall_o (cpu_stall_o)
  );

endmodule

// File: tb/tb_peripheral_dbg_pu_riscv_cpu_sequencer.sv
module tb_peripheral_dbg_pu_riscv_cpu_sequencer;

  // 24 cores keeps a 5-bit index, so out-of-range indices are reachable.
  localparam int CORES = 24;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int TMO   = 4;
  localparam int IDXW  = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   req_valid, req_ready, req_we;
  logic [IDXW-1:0]        req_core;
  logic [AW-1:0]          req_addr;
  logic [DW-1:0]          req_data;
  logic                   rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0]          rsp_data;
  logic [CORES*AW-1:0]    cpu_addr;
  logic [CORES*DW-1:0]    cpu_wdata, cpu_rdata;
  logic [CORES-1:0]       cpu_stb, cpu_we, cpu_ack, cpu_bp;
  logic [CORES-1:0]       stall_set, stall_clr, cpu_stall;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  peripheral_dbg_pu_riscv_cpu_sequencer #(
    .CORES          (CORES),
    .CPU_ADDR_WIDTH (AW),
    .CPU_DATA_WIDTH (DW),
    .TIMEOUT        (TMO)
  ) dut (
    .cpu_clk_i   (clk),
    .cpu_rst_i   (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_core_i  (req_core),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_we_i    (req_we),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .rsp_err_o   (rsp_err),
    .cpu_addr_o  (cpu_addr),
    .cpu_data_o  (cpu_wdata),
    .cpu_data_i  (cpu_rdata),
    .cpu_stb_o   (cpu_stb),
    .cpu_we_o    (cpu_we),
    .cpu_ack_i   (cpu_ack),
    .cpu_bp_i    (cpu_bp),
    .stall_set_i (stall_set),
    .stall_clr_i (stall_clr),
    .cpu_stall_o (cpu_stall)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int bad;
    logic [4:0] bad_idx [2];
    bad_idx[0] = 5'd24;
    bad_idx[1] = 5'd31;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_core = '0;
    req_addr = '0; req_data = '0; rsp_ready = 1'b0;
    cpu_rdata = '0; cpu_ack = '0; cpu_bp = '0; stall_set = '0; stall_clr = '0;
    tick(); tick();

    // ---------------- reset state ----------------
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data",  64'(rsp_data),  64'd0);
    chk("rst_rsp_err",   64'(rsp_err),   64'd0);
    chk("rst_stb",       64'(cpu_stb),   64'd0);
    chk("rst_we",        64'(cpu_we),    64'd0);
    chk("rst_addr_ones", 64'($countones(cpu_addr)),  64'd0);
    chk("rst_data_ones", 64'($countones(cpu_wdata)), 64'd0);
    chk("rst_stall",     64'(cpu_stall), 64'd0);
    rst = 1'b0;
    tick();

    // ---------------- read core 5, ack on 3rd ACCESS cycle ----------------
    cpu_rdata[5*DW  +: DW] = 32'hDEADBEEF;
    cpu_rdata[4*DW  +: DW] = 32'hFFFFFFFF;
    cpu_rdata[23*DW +: DW] = 32'hAAAA5555;
    req_valid = 1'b1; req_core = 5'd5; req_addr = 32'h100;
    req_data = 32'h0BAD0BAD; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
    chk("rd_req_ready", 64'(req_ready), 64'd0);
    chk("rd_addr_lane5", 64'(cpu_addr[5*AW +: AW]), 64'h100);
    chk("rd_addr_ones", 64'($countones(cpu_addr)), 64'd1);
    chk("rd_we", 64'(cpu_we), 64'd0);
    cpu_ack[4] = 1'b1;  // foreign ack must be ignored
    n = 0; bad = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) break;
      if (cpu_stb == 24'h000020) n++;
      if ((cpu_stb & ~24'h000020) != '0) bad++;
      if (n == 3) cpu_ack = 24'h000020;
      tick();
    end
    cpu_ack = '0;
    chk("rd_stb_cycles", 64'(n), 64'd3);
    chk("rd_stb_foreign", 64'(bad), 64'd0);
    chk("rd_stb_dropped", 64'(cpu_stb), 64'd0);
    chk("rd_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("rd_rsp_data", 64'(rsp_data), 64'hDEADBEEF);
    chk("rd_rsp_err", 64'(rsp_err), 64'd0);
    release_rsp();
    chk("rd_back_idle", 64'(req_ready), 64'd1);

    // ---------------- out-of-range core index ----------------
    for (int j = 0; j < 2; j++) begin
      req_valid = 1'b1; req_core = bad_idx[j];
      tick();
      req_valid = 1'b0;
      chk("bad_idx_stb", 64'(cpu_stb), 64'd0);
      chk("bad_idx_valid", 64'(rsp_valid), 64'd1);
      chk("bad_idx_err", 64'(rsp_err), 64'd1);
      chk("bad_idx_data", 64'(rsp_data), 64'd0);
      release_rsp();
    end

    // ---------------- write core 23, immediate ack ----------------
    req_valid = 1'b1; req_core = 5'd23; req_addr = 32'h44;
    req_data = 32'h12345678; req_we = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("wr_stb", 64'(cpu_stb), 64'h800000);
    chk("wr_we", 64'(cpu_we), 64'h800000);
    chk("wr_data_lane23", 64'(cpu_wdata[23*DW +: DW]), 64'h12345678);
    chk("wr_data_ones", 64'($countones(cpu_wdata)), 64'($countones(32'h12345678)));
    cpu_ack[23] = 1'b1;
    tick();
    cpu_ack = '0;
    chk("wr_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wr_rsp_data", 64'(rsp_data), 64'd0);
    chk("wr_rsp_err", 64'(rsp_err), 64'd0);
    chk("wr_stb_dropped", 64'(cpu_stb), 64'd0);

    // ---------------- response backpressure ----------------
    req_valid = 1'b1; req_core = 5'd1; req_we = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
      chk("bp_req_ready", 64'(req_ready), 64'd0);
      chk("bp_stb", 64'(cpu_stb), 64'd0);
    end
    req_valid = 1'b0;
    release_rsp();
    chk("bp_released", 64'(rsp_valid), 64'd0);

    // ---------------- stall vector ----------------
    cpu_bp[7] = 1'b1; tick();
    chk("stall_bp7", 64'(cpu_stall), 64'h80);
    cpu_bp[7] = 1'b0; tick();
    chk("stall_hold7", 64'(cpu_stall), 64'h80);
    stall_set[3] = 1'b1; stall_clr[3] = 1'b1; tick();
    chk("stall_setclr3", 64'(cpu_stall), 64'h88);
    stall_set[3] = 1'b0; tick();
    chk("stall_clr3", 64'(cpu_stall), 64'h80);
    stall_clr[3] = 1'b0;
    cpu_bp[7] = 1'b1; stall_clr[7] = 1'b1; tick();
    chk("stall_bp_beats_clr", 64'(cpu_stall), 64'h80);
    cpu_bp[7] = 1'b0; tick();
    chk("stall_clr7", 64'(cpu_stall), 64'h0);
    stall_clr[7] = 1'b0;
    stall_set[0] = 1'b1; tick();
    stall_set[0] = 1'b0;
    chk("stall_set0", 64'(cpu_stall), 64'h1);

    // ---------------- core 2 never acks ----------------
    req_valid = 1'b1; req_core = 5'd2; req_we = 1'b0;
    tick();
    req_valid = 1'b0;
`ifdef PERIPHERAL_DBG_CPU_TIMEOUT_EN
    n = 0;
    for (int k = 0; k < 20; k++) begin
      if (rsp_valid) break;
      if (cpu_stb == 24'h000004) n++;
      tick();
    end
    chk("tmo_stb_cycles", 64'(n), 64'(TMO));
    chk("tmo_rsp_valid", 64'(rsp_valid), 64'd1);
    chk("tmo_rsp_err", 64'(rsp_err), 64'd1);
    chk("tmo_rsp_data", 64'(rsp_data), 64'd0);
    chk("tmo_stb_dropped", 64'(cpu_stb), 64'd0);
    release_rsp();
    req_valid = 1'b1; req_core = 5'd9;
    tick();
    req_valid = 1'b0;
    tick();
    chk("pre_rst_stb9", 64'(cpu_stb), 64'h200);
`else
    n = 0;
    for (int k = 0; k < 1000; k++) begin
      if (cpu_stb == 24'h000004) n++;
      tick();
    end
    chk("wait_stb_cycles", 64'(n), 64'd1000);
    chk("wait_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("wait_req_ready", 64'(req_ready), 64'd0);
`endif

    // ---------------- reset in the middle of ACCESS ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_stb", 64'(cpu_stb), 64'd0);
    chk("mid_rst_addr_ones", 64'($countones(cpu_addr)), 64'd0);
    chk("mid_rst_req_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("mid_rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("mid_rst_stall", 64'(cpu_stall), 64'd0);
    cpu_ack = 24'hFFFFFF;  // a late ack must not revive the discarded access
    tick();
    cpu_ack = '0;
    chk("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("post_rst_req_ready", 64'(req_ready), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
